// File: rtl/instruction_dispatch_if.sv
// Instruction dispatch bus: instruction handshake, sub-FSM start/done
// lines and dispatcher status, bundled for the instruction_dispatch block.
// The slave modport is the dispatcher; master is the surrounding datapath.
interface instruction_dispatch_if #(
  parameter int COUNT_W = 16
);
  logic [15:0]        instruction;
  logic               instr_valid;
  logic               instr_ready;
  logic [3:0]         FSM_start;
  logic [3:0]         opcode;
  logic [5:0]         param1;
  logic [5:0]         param2;
  logic               ALU_FSM_DONE;
  logic               ALUI_FSM_DONE;
  logic               MOVE_FSM_DONE;
  logic               MOVI_FSM_DONE;
  logic               STORE_FSM_DONE;
  logic               LOAD_FSM_DONE;
  logic               DONE;
  logic               busy;
  logic [COUNT_W-1:0] instr_count;
  logic               seq_error;

  modport slave (
    input  instruction, instr_valid,
    input  ALU_FSM_DONE, ALUI_FSM_DONE, MOVE_FSM_DONE,
    input  MOVI_FSM_DONE, STORE_FSM_DONE, LOAD_FSM_DONE,
    output instr_ready, FSM_start, opcode, param1, param2,
    output DONE, busy, instr_count, seq_error
  );

  modport master (
    output instruction, instr_valid,
    output ALU_FSM_DONE, ALUI_FSM_DONE, MOVE_FSM_DONE,
    output MOVI_FSM_DONE, STORE_FSM_DONE, LOAD_FSM_DONE,
    input  instr_ready, FSM_start, opcode, param1, param2,
    input  DONE, busy, instr_count, seq_error
  );
endinterface

// File: rtl/instruction_dispatch.sv
// instruction_dispatch: accepts one 16-bit instruction per valid/ready
// handshake, starts the matching sub-FSM and retires the instruction when
// that FSM reports done. Done lines from unselected FSMs (or any done while
// idle) set the sticky seq_error flag.
// Optional feature: define DISPATCH_TIMEOUT_EN to abort an instruction whose
// sub-FSM has not finished within TIMEOUT_CYCLES cycles. The TIMEOUT_CYCLES
// parameter exists only in that build.
module instruction_dispatch #(
  parameter int COUNT_W = 16
`ifdef DISPATCH_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                  clock,
  input  logic                  reset,
  instruction_dispatch_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    WAIT
  } state_e;

  typedef enum logic [3:0] {
    CODE_NONE  = 4'd0,
    CODE_ALU   = 4'd1,
    CODE_MOVE  = 4'd2,
    CODE_ALUI  = 4'd3,
    CODE_MOVI  = 4'd4,
    CODE_STORE = 4'd5,
    CODE_LOAD  = 4'd6
  } fsm_code_e;

  // Opcode map: 0x0-0x7 ALU, 0x8-0xB ALUI, then MOVE/MOVI/STORE/LOAD.
  function automatic fsm_code_e decode(input logic [3:0] op);
    if (!op[3])               return CODE_ALU;
    else if (op[3:2] == 2'b10) return CODE_ALUI;
    else begin
      case (op[1:0])
        2'd0:    return CODE_MOVE;
        2'd1:    return CODE_MOVI;
        2'd2:    return CODE_STORE;
        default: return CODE_LOAD;
      endcase
    end
  endfunction

  state_e             state_q, state_d;
  fsm_code_e          code_q;
  logic [3:0]         opcode_q;
  logic [5:0]         param1_q, param2_q;
  logic               done_q;
  logic [COUNT_W-1:0] count_q;
  logic               seq_error_q;

  logic               active;
  logic [6:0]         done_vec;
  logic [6:0]         sel_mask;
  logic               sel_done;
  logic               spurious;
  logic               accept;
  logic               retire;
  logic               abort;

  // Done lines indexed by sub-FSM code; bit 0 (no FSM) is never set.
  assign done_vec = {bus.LOAD_FSM_DONE, bus.STORE_FSM_DONE, bus.MOVI_FSM_DONE,
                     bus.ALUI_FSM_DONE, bus.MOVE_FSM_DONE, bus.ALU_FSM_DONE,
                     1'b0};

  assign active   = (state_q != IDLE);
  assign sel_mask = 7'b1 << code_q;
  assign sel_done = active && |(done_vec & sel_mask);
  assign spurious = active ? |(done_vec & ~sel_mask) : |done_vec;

`ifdef DISPATCH_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TIMER_W-1:0] timer_q;
  logic               timer_expired;

  assign timer_expired = (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

  // Cycle counter for the current instruction, restarted on every accept.
  always_ff @(posedge clock) begin
    if (!reset)      timer_q <= '0;
    else if (accept) timer_q <= '0;
    else if (active) timer_q <= timer_q + TIMER_W'(1);
  end
`else
  logic timer_expired;
  assign timer_expired = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement or process order.
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and per-cycle events.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    accept  = 1'b0;
    retire  = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.instr_valid) begin
          accept  = 1'b1;
          state_d = DISPATCH;
        end
      end
      DISPATCH, WAIT: begin
        if (sel_done) begin
          retire  = 1'b1;
          state_d = IDLE;
        end else if (timer_expired) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Instruction fields and selected FSM, latched on accept.
  always_ff @(posedge clock) begin
    if (!reset) begin
      opcode_q <= '0;
      param1_q <= '0;
      param2_q <= '0;
      code_q   <= CODE_NONE;
    end else if (accept) begin
      opcode_q <= bus.instruction[15:12];
      param1_q <= bus.instruction[11:6];
      param2_q <= bus.instruction[5:0];
      code_q   <= decode(bus.instruction[15:12]);
    end
  end

  // Retire pulse, retired-instruction counter and sticky error flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      done_q      <= 1'b0;
      count_q     <= '0;
      seq_error_q <= 1'b0;
    end else begin
      done_q      <= retire;
      if (retire) count_q <= count_q + COUNT_W'(1);
      seq_error_q <= seq_error_q | spurious | abort;
    end
  end

  assign bus.instr_ready = (state_q == IDLE);
  assign bus.busy        = active;
  assign bus.FSM_start   = active ? code_q : CODE_NONE;
  assign bus.opcode      = opcode_q;
  assign bus.param1      = param1_q;
  assign bus.param2      = param2_q;
  assign bus.DONE        = done_q;
  assign bus.instr_count = count_q;
  assign bus.seq_error   = seq_error_q;

endmodule

// File: tb/tb_instruction_dispatch.sv
// Directed self-checking bench for instruction_dispatch. Inputs change 1 ns
// after each rising edge and outputs are checked at that same point.
module tb_instruction_dispatch;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  instruction_dispatch_if #(.COUNT_W(16)) bus ();

  instruction_dispatch #(
    .COUNT_W(16)
`ifdef DISPATCH_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_done(input int code, input logic v);
    case (code)
      1: bus.ALU_FSM_DONE   = v;
      2: bus.MOVE_FSM_DONE  = v;
      3: bus.ALUI_FSM_DONE  = v;
      4: bus.MOVI_FSM_DONE  = v;
      5: bus.STORE_FSM_DONE = v;
      6: bus.LOAD_FSM_DONE  = v;
      default: ;
    endcase
  endtask

  task automatic drive(input logic [15:0] instr);
    bus.instruction = instr;
    bus.instr_valid = 1'b1;
  endtask

  logic [3:0] t3_op   [5] = '{4'h8, 4'hC, 4'hD, 4'hE, 4'hF};
  int         t3_code [5] = '{3, 2, 4, 5, 6};

  initial begin
    reset           = 1'b0;
    bus.instruction = '0;
    bus.instr_valid = 1'b0;
    for (int c = 1; c <= 6; c++) set_done(c, 1'b0);

    // Power-on reset state.
    tick();
    tick();
    check("rst_fsm_start", bus.FSM_start, 0);
    check("rst_opcode", bus.opcode, 0);
    check("rst_done", bus.DONE, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_count", bus.instr_count, 0);
    check("rst_seq_error", bus.seq_error, 0);
    check("rst_ready", bus.instr_ready, 1);
    reset = 1'b1;
    tick();

    // ALU instruction, done after 4 WAIT cycles.
    drive(16'h1042);
    tick();
    check("alu_dispatch_start", bus.FSM_start, 1);
    check("alu_opcode", bus.opcode, 1);
    check("alu_param1", bus.param1, 1);
    check("alu_param2", bus.param2, 2);
    check("alu_ready_busy", bus.instr_ready, 0);
    bus.instr_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("alu_wait_start", bus.FSM_start, 1);
      check("alu_wait_done", bus.DONE, 0);
      if (i == 3) set_done(1, 1'b1);
      tick();
    end
    set_done(1, 1'b0);
    check("alu_retire_done", bus.DONE, 1);
    check("alu_retire_start", bus.FSM_start, 0);
    check("alu_count", bus.instr_count, 1);
    tick();
    check("alu_done_pulse", bus.DONE, 0);

    // Back-to-back ALUI/MOVE/MOVI/STORE/LOAD, each done one cycle after start.
    for (int k = 0; k < 5; k++) begin
      drive({t3_op[k], 12'h5A5});
      tick();
      check("b2b_dispatch_start", bus.FSM_start, t3_code[k]);
      check("b2b_opcode", bus.opcode, t3_op[k]);
      bus.instr_valid = 1'b0;
      tick();
      check("b2b_wait_start", bus.FSM_start, t3_code[k]);
      set_done(t3_code[k], 1'b1);
      tick();
      set_done(t3_code[k], 1'b0);
      check("b2b_done", bus.DONE, 1);
    end
    tick();
    check("b2b_count", bus.instr_count, 6);
    check("b2b_seq_error", bus.seq_error, 0);

    // MOVI with done already high in DISPATCH, then an ALU accepted in the DONE cycle.
    drive(16'hD000);
    tick();
    bus.instr_valid = 1'b0;
    set_done(4, 1'b1);
    check("movi_start", bus.FSM_start, 4);
    tick();
    set_done(4, 1'b0);
    check("movi_done", bus.DONE, 1);
    check("movi_ready", bus.instr_ready, 1);
    drive(16'h2FFF);
    tick();
    check("tp_start", bus.FSM_start, 1);
    check("tp_opcode", bus.opcode, 2);
    check("tp_count_mid", bus.instr_count, 7);
    bus.instr_valid = 1'b0;
    set_done(1, 1'b1);
    tick();
    set_done(1, 1'b0);
    check("tp_done", bus.DONE, 1);
    check("tp_count", bus.instr_count, 8);
    check("tp_seq_error", bus.seq_error, 0);

    // LOAD waiting, spurious STORE done, then LOAD done retires.
    drive(16'hF000);
    tick();
    bus.instr_valid = 1'b0;
    tick();
    set_done(5, 1'b1);
    tick();
    set_done(5, 1'b0);
    check("spur_seq_error", bus.seq_error, 1);
    check("spur_busy", bus.busy, 1);
    check("spur_start", bus.FSM_start, 6);
    check("spur_no_done", bus.DONE, 0);
    set_done(6, 1'b1);
    tick();
    set_done(6, 1'b0);
    check("load_done", bus.DONE, 1);
    check("load_count", bus.instr_count, 9);
    check("load_seq_sticky", bus.seq_error, 1);

    // Reset held low 2 cycles while an ALU instruction is in WAIT.
    drive(16'h0000);
    tick();
    bus.instr_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("mid_rst_start", bus.FSM_start, 0);
    tick();
    reset = 1'b1;
    check("post_rst_start", bus.FSM_start, 0);
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_count", bus.instr_count, 0);
    check("post_rst_ready", bus.instr_ready, 1);
    check("post_rst_seq_error", bus.seq_error, 0);
    check("post_rst_opcode", bus.opcode, 0);

    // Any done while idle is a sequence error.
    set_done(2, 1'b1);
    tick();
    set_done(2, 1'b0);
    check("idle_spur_seq_error", bus.seq_error, 1);
    check("idle_spur_count", bus.instr_count, 0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rst_clears_seq_error", bus.seq_error, 0);

`ifdef DISPATCH_TIMEOUT_EN
    // No done: abort after 8 busy cycles, no retire.
    drive(16'h0000);
    tick();
    bus.instr_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("to_busy", bus.busy, 1);
      tick();
    end
    check("to_busy_after", bus.busy, 0);
    check("to_seq_error", bus.seq_error, 1);
    check("to_no_done", bus.DONE, 0);
    check("to_count", bus.instr_count, 0);
    check("to_ready", bus.instr_ready, 1);
    check("to_start", bus.FSM_start, 0);
`else
    // Without the timeout, WAIT holds until the selected done arrives.
    drive(16'h0000);
    tick();
    bus.instr_valid = 1'b0;
    repeat (40) tick();
    check("hold_busy", bus.busy, 1);
    check("hold_start", bus.FSM_start, 1);
    check("hold_seq_error", bus.seq_error, 0);
    set_done(1, 1'b1);
    tick();
    set_done(1, 1'b0);
    check("hold_done", bus.DONE, 1);
    check("hold_count", bus.instr_count, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
